io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_pkg.sv | 7 +
 rtl/io_inbuf.sv | 46 ++++
 rtl/io_ctrl.sv | 102 ++++++++++
 tb/tb_io_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and the port-id type for the CPU I/O controller.
package io_pkg;
  localparam int IO_NP = 4;
  localparam int IO_DW = 8;
  localparam int PID_W = 2;
  typedef logic [PID_W-1:0] port_id_t;
endpackage

// File: rtl/io_inbuf.sv
// Single-entry input buffer: captures a peripheral byte when empty, releases it on a CPU read.
module io_inbuf
  import io_pkg::*;
#(
  parameter int DW = IO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          rd,
  output logic [DW-1:0] data,
  output logic          full
);

  logic [DW-1:0] data_q, data_d;
  logic          full_q, full_d;

  // Capture needs an empty buffer and a read needs a full one, so the two never collide.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (in_valid && !full_q) begin
      data_d = in_data;
      full_d = 1'b1;
    end else if (rd && full_q) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign in_ready = !full_q;
  assign data     = data_q;
  assign full     = full_q;

endmodule

// File: rtl/io_ctrl.sv
// CPU I/O controller: buffered input ports, held output ports and a round-robin interrupt selector.
module io_ctrl
  import io_pkg::*;
#(
  parameter int DW = IO_DW,
  parameter int NP = IO_NP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NP-1:0]    in_valid,
  input  logic [NP*DW-1:0] in_data,
  output logic [NP-1:0]    in_ready,
  input  logic             rd_en,
  input  logic [1:0]       id_in,
  output logic [DW-1:0]    data_in,
  output logic             in_stall,
  input  logic             wr_en,
  input  logic [1:0]       id_out,
  input  logic [DW-1:0]    data_reg,
  output logic [NP*DW-1:0] out_data,
  output logic [NP-1:0]    out_valid,
  input  logic [NP-1:0]    out_ack,
  output logic             out_stall,
  output logic             irq,
  output logic [1:0]       irq_port
);

  logic [DW-1:0] buf_data [NP];
  logic [NP-1:0] full;
  logic [DW-1:0] hold_q [NP];
  logic [DW-1:0] hold_d [NP];
  logic [NP-1:0] valid_q, valid_d;
  port_id_t      rr_q, rr_d;
  port_id_t      scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_port
      io_inbuf #(.DW(DW)) u_inbuf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid[gi]),
        .in_data  (in_data[DW*gi +: DW]),
        .in_ready (in_ready[gi]),
        .rd       (rd_en && (id_in == PID_W'(gi))),
        .data     (buf_data[gi]),
        .full     (full[gi])
      );

      // A write may land in the same cycle the peripheral drains the old byte.
      always_comb begin
        hold_d[gi]  = hold_q[gi];
        valid_d[gi] = valid_q[gi];
        if (wr_en && (id_out == PID_W'(gi)) && (!valid_q[gi] || out_ack[gi])) begin
          hold_d[gi]  = data_reg;
          valid_d[gi] = 1'b1;
        end else if (out_ack[gi]) begin
          valid_d[gi] = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hold_q[gi]  <= '0;
          valid_q[gi] <= 1'b0;
        end else begin
          hold_q[gi]  <= hold_d[gi];
          valid_q[gi] <= valid_d[gi];
        end
      end

      assign out_data[DW*gi +: DW] = hold_q[gi];
    end
  endgenerate

  assign out_valid = valid_q;
  assign data_in   = full[id_in] ? buf_data[id_in] : '0;
  assign in_stall  = rd_en && !full[id_in];
  assign out_stall = wr_en && valid_q[id_out] && !out_ack[id_out];
  assign irq       = |full;

  // Scan from the farthest offset back to rr_q so the nearest full port wins.
  always_comb begin
    irq_port = rr_q;
    scan_idx = rr_q;
    for (int k = NP - 1; k >= 0; k--) begin
      scan_idx = rr_q + PID_W'(k);
      if (full[scan_idx]) irq_port = scan_idx;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (rd_en && full[id_in]) rr_d = id_in + 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end

endmodule

// File: tb/tb_io_ctrl.sv
// Directed-vector bench for io_ctrl with hand-computed expectations.
module tb_io_ctrl;
  localparam int DW = 8;
  localparam int NP = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    in_valid;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_ready;
  logic             rd_en;
  logic [1:0]       id_in;
  logic [DW-1:0]    data_in;
  logic             in_stall;
  logic             wr_en;
  logic [1:0]       id_out;
  logic [DW-1:0]    data_reg;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    out_ack;
  logic             out_stall;
  logic             irq;
  logic [1:0]       irq_port;

  int n_vec = 0;
  int n_err = 0;

  io_ctrl #(.DW(DW), .NP(NP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_en     (rd_en),
    .id_in     (id_in),
    .data_in   (data_in),
    .in_stall  (in_stall),
    .wr_en     (wr_en),
    .id_out    (id_out),
    .data_reg  (data_reg),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .out_stall (out_stall),
    .irq       (irq),
    .irq_port  (irq_port)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    rd_en    = 1'b1;
    id_in    = 2'd0;
    wr_en    = 1'b0;
    id_out   = 2'd0;
    data_reg = '0;
    out_ack  = '0;
    #12;
    check_vec("rst_in_ready",  32'(in_ready), 32'hF);
    check_vec("rst_data_in",   32'(data_in), 32'h0);
    check_vec("rst_in_stall",  32'(in_stall), 32'h1);
    check_vec("rst_out_stall", 32'(out_stall), 32'h0);
    check_vec("rst_irq",       32'(irq), 32'h0);
    check_vec("rst_irq_port",  32'(irq_port), 32'h0);
    check_vec("rst_out_valid", 32'(out_valid), 32'h0);
    rd_en = 1'b0;
    reset = 1'b1;

    // capture then read on port 2
    tick();
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    in_valid = '0;
    check_vec("cap_in_ready", 32'(in_ready), 32'hB);
    check_vec("cap_irq_port", 32'(irq_port), 32'h2);
    rd_en = 1'b1; id_in = 2'd2;
    #1;
    check_vec("rd2_data_in",  32'(data_in), 32'hA5);
    check_vec("rd2_in_stall", 32'(in_stall), 32'h0);
    tick();
    rd_en = 1'b0;
    check_vec("rd2_in_ready", 32'(in_ready), 32'hF);
    check_vec("rd2_irq",      32'(irq), 32'h0);
    check_vec("rd2_rr_idle",  32'(irq_port), 32'h3);

    // read of an empty port stalls until data arrives
    rd_en = 1'b1; id_in = 2'd1;
    #1;
    check_vec("rd1_stall",   32'(in_stall), 32'h1);
    check_vec("rd1_data_in", 32'(data_in), 32'h0);
    tick();
    check_vec("rd1_in_ready", 32'(in_ready), 32'hF);
    check_vec("rd1_rr_hold",  32'(irq_port), 32'h3);
    in_valid = 4'b0010;
    in_data  = {8'h00, 8'h00, 8'h3C, 8'h00};
    tick();
    in_valid = '0;
    check_vec("rd1_unstall", 32'(in_stall), 32'h0);
    check_vec("rd1_data",    32'(data_in), 32'h3C);
    check_vec("rd1_irq_port", 32'(irq_port), 32'h1);
    tick();
    rd_en = 1'b0;
    check_vec("rd1_done_ready", 32'(in_ready), 32'hF);
    check_vec("rd1_rr",         32'(irq_port), 32'h2);

    // output port 3: write, blocked write, write with ack
    wr_en = 1'b1; id_out = 2'd3; data_reg = 8'h11;
    #1;
    check_vec("wr3_first_stall", 32'(out_stall), 32'h0);
    tick();
    data_reg = 8'h22;
    #1;
    check_vec("wr3_full_stall", 32'(out_stall), 32'h1);
    tick();
    check_vec("wr3_hold_old", 32'(out_data[31:24]), 32'h11);
    check_vec("wr3_valid",    32'(out_valid), 32'h8);
    out_ack = 4'b1000;
    #1;
    check_vec("wr3_ack_stall", 32'(out_stall), 32'h0);
    tick();
    wr_en = 1'b0; out_ack = '0;
    check_vec("wr3_hold_new", 32'(out_data[31:24]), 32'h22);
    check_vec("wr3_valid2",   32'(out_valid), 32'h8);
    out_ack = 4'b1001;
    tick();
    out_ack = '0;
    check_vec("ack3_clear", 32'(out_valid), 32'h0);

    // move rr_ptr to 0 via a read of port 3
    in_valid = 4'b1000;
    in_data  = {8'h77, 8'h00, 8'h00, 8'h00};
    tick();
    in_valid = '0;
    rd_en = 1'b1; id_in = 2'd3;
    #1;
    check_vec("rd3_data", 32'(data_in), 32'h77);
    tick();
    rd_en = 1'b0;

    // round-robin with ports 0 and 2 full
    in_valid = 4'b0101;
    in_data  = {8'h00, 8'h20, 8'h00, 8'h10};
    tick();
    in_valid = '0;
    check_vec("rr_irq",   32'(irq), 32'h1);
    check_vec("rr_sel0",  32'(irq_port), 32'h0);
    rd_en = 1'b1; id_in = 2'd0;
    #1;
    check_vec("rr_rd0", 32'(data_in), 32'h10);
    tick();
    check_vec("rr_sel2", 32'(irq_port), 32'h2);
    id_in = 2'd2;
    #1;
    check_vec("rr_rd2", 32'(data_in), 32'h20);
    tick();
    rd_en = 1'b0;
    check_vec("rr_irq_off", 32'(irq), 32'h0);
    check_vec("rr_ptr3",    32'(irq_port), 32'h3);

    // wrap-around: rr_ptr=3, only port 0 full
    in_valid = 4'b0001;
    in_data  = {8'h00, 8'h00, 8'h00, 8'h99};
    tick();
    in_valid = '0;
    check_vec("wrap_sel0", 32'(irq_port), 32'h0);

    // simultaneous read of port 0 and write of port 1
    rd_en = 1'b1; id_in = 2'd0;
    wr_en = 1'b1; id_out = 2'd1; data_reg = 8'h5A;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check_vec("both_in_ready",  32'(in_ready), 32'hF);
    check_vec("both_out_valid", 32'(out_valid), 32'h2);
    check_vec("both_out_data",  32'(out_data[15:8]), 32'h5A);
    check_vec("both_rr",        32'(irq_port), 32'h1);

    // fill everything, then reset asynchronously between edges
    in_valid = 4'b1111;
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    in_valid = '0;
    for (int p = 0; p < NP; p++) begin
      if (p != 1) begin
        wr_en = 1'b1; id_out = 2'(p); data_reg = 8'(8'hC0 + p);
        tick();
      end
    end
    wr_en = 1'b0;
    check_vec("pre_rst_valid", 32'(out_valid), 32'hF);
    check_vec("pre_rst_ready", 32'(in_ready), 32'h0);
    check_vec("pre_rst_irq",   32'(irq), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check_vec("arst_ready",    32'(in_ready), 32'hF);
    check_vec("arst_irq",      32'(irq), 32'h0);
    check_vec("arst_valid",    32'(out_valid), 32'h0);
    check_vec("arst_out_data", out_data, 32'h0);
    check_vec("arst_irq_port", 32'(irq_port), 32'h0);
    check_vec("arst_data_in",  32'(data_in), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
